// File: rtl/mac_out_stage_pkg.sv
// mac_out_stage_pkg: mode encodings and pipeline-depth limits shared by the MAC output stage.
package mac_out_stage_pkg;
  typedef logic [1:0] mode_t;
  localparam mode_t MODE_ADD  = 2'b00;
  localparam mode_t MODE_MAC  = 2'b01;
  localparam mode_t MODE_HALF = 2'b10;
  localparam mode_t MODE_FULL = 2'b11;
  localparam int PIPE_MIN = 1;
  localparam int PIPE_MAX = 4;
endpackage

// File: rtl/mac_out_stage_pipe.sv
// mac_out_pipe: DEPTH-stage delay line for packed {valid, clr, mode, result} words.
module mac_out_pipe #(
  parameter int DW    = 8,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);
  logic [DW-1:0] stage_q [DEPTH];
  logic [DW-1:0] stage_d [DEPTH];
  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    else stage_q <= stage_d;
  assign q = stage_q[DEPTH-1];
endmodule

// File: rtl/mac_out_stage.sv
// mac_out_stage: pipelined ADD/MAC/HALF/FULL result selector with accumulator and sticky overflow.
// Define MAC_OUT_STAGE_SAT_EN to make MAC accumulation saturate instead of wrap.
module mac_out_stage
  import mac_out_stage_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PIPE  = 2
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               IN_VALID,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [1:0]         SELM,
  input  logic               ACC_CLR,
  output logic [2*WIDTH-1:0] OUT,
  output logic               OUT_VALID,
  output logic               ACC_OVF
);
  localparam int P  = PIPE < PIPE_MIN ? PIPE_MIN : PIPE > PIPE_MAX ? PIPE_MAX : PIPE;
  localparam int RW = 2 * WIDTH;
  localparam int H  = WIDTH / 2;
  localparam int DW = RW + 4;
  logic             s1_valid, s1_clr;
  mode_t            s1_mode;
  logic [WIDTH-1:0] s1_a, s1_b;
  generate
    if (P == 1) begin : g_s1_comb
      assign {s1_valid, s1_clr, s1_mode, s1_a, s1_b} = {IN_VALID, ACC_CLR, SELM, A, B};
    end else begin : g_s1_reg
      logic [DW-1:0] s1_q, s1_d;
      always_comb s1_d = {IN_VALID, ACC_CLR, SELM, A, B};
      always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) s1_q <= '0;
        else s1_q <= s1_d;
      assign {s1_valid, s1_clr, s1_mode, s1_a, s1_b} = s1_q;
    end
  endgenerate
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] half;
  logic [RW-1:0]    prod, res;
  always_comb begin
    sum  = {1'b0, s1_a} + {1'b0, s1_b};
    half = WIDTH'(s1_a[H-1:0]) * WIDTH'(s1_b[H-1:0]);
    prod = RW'(s1_a) * RW'(s1_b);
    res  = s1_mode == MODE_ADD  ? RW'(sum) :
           s1_mode == MODE_HALF ? RW'(half) :
           (s1_mode == MODE_MAC || s1_mode == MODE_FULL) ? prod : '0;
  end
  // MAC carries the raw product; the accumulate happens in the last stage only.
  logic [DW-1:0] p_in, p_out;
  assign p_in = {s1_valid, s1_clr, s1_mode, res};
  generate
    if (P >= 3) begin : g_dly
      mac_out_pipe #(.DW(DW), .DEPTH(P - 2)) u_pipe (
        .clk  (CLK),
        .rst_n(RST_N),
        .d    (p_in),
        .q    (p_out)
      );
    end else begin : g_nodly
      assign p_out = p_in;
    end
  endgenerate
  logic          p_valid, p_clr, mac;
  mode_t         p_mode;
  logic [RW-1:0] p_res, out_q, out_d, acc_q, acc_d;
  logic [RW:0]   acc_sum;
  logic          vld_q, vld_d, ovf_q, ovf_d;
  assign {p_valid, p_clr, p_mode, p_res} = p_out;
  always_comb begin
    mac     = p_valid && p_mode == MODE_MAC;
    acc_sum = {1'b0, p_clr ? {RW{1'b0}} : acc_q} + {1'b0, p_res};
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    out_d   = out_q;
    vld_d   = p_valid;
    if (mac) begin
`ifdef MAC_OUT_STAGE_SAT_EN
      acc_d = acc_sum[RW] ? '1 : acc_sum[RW-1:0];
`else
      acc_d = acc_sum[RW-1:0];
`endif
      ovf_d = (ovf_q & ~p_clr) | acc_sum[RW];
    end else if (!p_valid && p_clr) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end
    if (p_valid) out_d = mac ? acc_d : p_res;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      out_q <= '0;
      acc_q <= '0;
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      acc_q <= acc_d;
      vld_q <= vld_d;
      ovf_q <= ovf_d;
    end
  assign OUT       = out_q;
  assign OUT_VALID = vld_q;
  assign ACC_OVF   = ovf_q;
endmodule

// File: tb/tb_mac_out_stage.sv
// tb_mac_out_stage: directed checks of mac_out_stage at PIPE=2 and PIPE=4 (WIDTH=16).
module tb_mac_out_stage;
  import mac_out_stage_pkg::*;
`ifdef MAC_OUT_STAGE_SAT_EN
  localparam logic [31:0] OV2 = 32'hFFFF_FFFF;
  localparam logic [31:0] OV3 = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] OV2 = 32'hFFFC_0002;
  localparam logic [31:0] OV3 = 32'hFFFA_0003;
`endif
  logic        clk = 1'b0;
  logic        rst2_n, rst4_n, in_valid, acc_clr;
  logic [15:0] a, b;
  logic [1:0]  selm;
  logic [31:0] out2, out4;
  logic        vld2, vld4, ovf2, ovf4;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mac_out_stage #(.WIDTH(16), .PIPE(2)) dut2 (
    .CLK(clk), .RST_N(rst2_n), .IN_VALID(in_valid), .A(a), .B(b), .SELM(selm),
    .ACC_CLR(acc_clr), .OUT(out2), .OUT_VALID(vld2), .ACC_OVF(ovf2)
  );
  mac_out_stage #(.WIDTH(16), .PIPE(4)) dut4 (
    .CLK(clk), .RST_N(rst4_n), .IN_VALID(in_valid), .A(a), .B(b), .SELM(selm),
    .ACC_CLR(acc_clr), .OUT(out4), .OUT_VALID(vld4), .ACC_OVF(ovf4)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input logic v, input mode_t m, input logic [15:0] aa, input logic [15:0] bb, input logic c);
    in_valid = v;
    selm     = m;
    a        = aa;
    b        = bb;
    acc_clr  = c;
  endtask
  initial begin
    rst2_n = 1'b0;
    rst4_n = 1'b0;
    drv(0, MODE_ADD, 0, 0, 0);
    #12;
    chk("rst_out", out2, 0);
    chk("rst_vld", vld2, 0);
    chk("rst_ovf", ovf2, 0);
    chk("rst_out4", out4, 0);
    @(negedge clk);
    rst2_n = 1'b1;
    rst4_n = 1'b1;
    cyc();
    // ADD latency and carry-out bit
    drv(1, MODE_ADD, 16'hFFFF, 16'h0001, 0);
    cyc();
    drv(0, MODE_ADD, 0, 0, 0);
    chk("add_lat1_vld", vld2, 0);
    cyc();
    chk("add_out", out2, 32'h0001_0000);
    chk("add_vld", vld2, 1);
    drv(1, MODE_ADD, 16'hFFFF, 16'hFFFF, 0);
    cyc();
    drv(0, MODE_ADD, 0, 0, 0);
    chk("idle_vld", vld2, 0);
    chk("idle_hold", out2, 32'h0001_0000);
    cyc();
    chk("add_max", out2, 32'h0001_FFFE);
    // MAC stream
    drv(1, MODE_MAC, 3, 4, 1);
    cyc();
    drv(1, MODE_MAC, 5, 6, 0);
    cyc();
    chk("mac1", out2, 12);
    chk("mac1_vld", vld2, 1);
    drv(1, MODE_MAC, 2, 2, 0);
    cyc();
    chk("mac2", out2, 42);
    drv(0, MODE_ADD, 0, 0, 0);
    cyc();
    chk("mac3", out2, 46);
    chk("mac3_ovf", ovf2, 0);
    // overflow
    drv(1, MODE_MAC, 16'hFFFF, 16'hFFFF, 1);
    cyc();
    drv(1, MODE_MAC, 16'hFFFF, 16'hFFFF, 0);
    cyc();
    chk("ovf1", out2, 32'hFFFE_0001);
    chk("ovf1_flag", ovf2, 0);
    cyc();
    drv(0, MODE_ADD, 0, 0, 0);
    chk("ovf2", out2, OV2);
    chk("ovf2_flag", ovf2, 1);
    cyc();
    chk("ovf3", out2, OV3);
    chk("ovf3_flag", ovf2, 1);
    // mixed modes around the accumulator
    drv(1, MODE_MAC, 3, 4, 1);
    cyc();
    drv(1, MODE_FULL, 16'h1234, 16'h0100, 0);
    cyc();
    chk("mix_load", out2, 12);
    chk("mix_load_ovf", ovf2, 0);
    drv(1, MODE_HALF, 16'h1234, 16'h0100, 0);
    cyc();
    chk("mix_full", out2, 32'h0012_3400);
    drv(1, MODE_MAC, 1, 1, 0);
    cyc();
    chk("mix_half", out2, 32'h0000_0000);
    chk("mix_half_vld", vld2, 1);
    drv(0, MODE_ADD, 0, 0, 0);
    cyc();
    chk("mix_acc_kept", out2, 13);
    // bubble clear after an overflow
    drv(1, MODE_MAC, 16'hFFFF, 16'hFFFF, 1);
    cyc();
    drv(1, MODE_MAC, 16'hFFFF, 16'hFFFF, 0);
    cyc();
    drv(0, MODE_ADD, 0, 0, 1);
    cyc();
    chk("bub_pre_ovf", ovf2, 1);
    drv(1, MODE_MAC, 1, 1, 0);
    cyc();
    drv(0, MODE_ADD, 0, 0, 0);
    chk("bub_vld", vld2, 0);
    chk("bub_hold", out2, OV2);
    chk("bub_ovf", ovf2, 0);
    cyc();
    chk("bub_mac", out2, 1);
    chk("bub_mac_ovf", ovf2, 0);
    cyc();
    cyc();
    chk("p4_out", out4, 1);
    chk("p4_ovf", ovf4, 0);
    // PIPE=4 reset mid-stream
    drv(1, MODE_MAC, 5, 5, 1);
    cyc();
    drv(1, MODE_MAC, 5, 5, 0);
    cyc();
    cyc();
    drv(0, MODE_ADD, 0, 0, 0);
    rst4_n = 1'b0;
    #1;
    chk("p4_async_out", out4, 0);
    chk("p4_async_vld", vld4, 0);
    cyc();
    rst4_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("p4_flushed_vld", vld4, 0);
    end
    drv(1, MODE_MAC, 2, 3, 0);
    cyc();
    drv(0, MODE_ADD, 0, 0, 0);
    cyc();
    cyc();
    chk("p4_lat3_vld", vld4, 0);
    cyc();
    chk("p4_lat4_vld", vld4, 1);
    chk("p4_acc_zero", out4, 6);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
